// File: rtl/gf180mcu_cell_bist3.sv
// gf180mcu_cell_bist3: exhaustive Gray-order BIST driver/checker for a 3-input std cell
module gf180mcu_cell_bist3 #(
  parameter int         SETTLE_CYC = 2,
  parameter int         PASSES     = 1,
  parameter logic [7:0] TRUTH      = 8'h7F,
  parameter int         ERR_W      = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ZN,
  output logic             A1,
  output logic             A2,
  output logic             A3,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [2:0]       FIRST_FAIL,
  output logic [7:0]       SIG,
  inout  wire              VDD,
  inout  wire              VSS
);
  if (SETTLE_CYC < 1 || SETTLE_CYC > 15 || PASSES < 1 || PASSES > 255 || ERR_W < 1) begin : g_bad
    $error("gf180mcu_cell_bist3: illegal parameter value");
  end
  localparam logic [1:0] IDLE = 2'd0, SETTLE = 2'd1, SAMPLE = 2'd2, FINISH = 2'd3;
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYC - 1);
  localparam logic [7:0] LAST_PASS = 8'(PASSES - 1);
  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d, nxt_idx;
  logic [7:0]       pas_q, pas_d;
  logic [2:0]       code_q, code_d;
  logic [ERR_W-1:0] err_q, err_d, err_inc;
  logic [2:0]       ff_q, ff_d;
  logic [7:0]       sig_q, sig_d;
  logic             pass_q, pass_d;
  logic             miss, last;
  assign nxt_idx = idx_q + 3'd1;
  assign miss    = ZN != TRUTH[code_q];
  assign last    = idx_q == 3'd7 && pas_q == LAST_PASS;
  assign err_inc = (miss && !(&err_q)) ? err_q + 1'b1 : err_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pas_d   = pas_q;
    code_d  = code_q;
    err_d   = err_q;
    ff_d    = ff_q;
    sig_d   = sig_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: if (START) begin
        state_d = SETTLE;
        cnt_d   = CNT_INIT;
        idx_d   = '0;
        pas_d   = '0;
        code_d  = '0;
        err_d   = '0;
        ff_d    = '0;
        sig_d   = '0;
        pass_d  = 1'b0;
      end
      SETTLE: begin
        cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
        state_d = (cnt_q == 4'd0) ? SAMPLE : SETTLE;
      end
      SAMPLE: begin
        err_d = err_inc;
        ff_d  = (miss && err_q == '0) ? code_q : ff_q;
        sig_d = {sig_q[6:0], sig_q[7] ^ sig_q[5] ^ sig_q[4] ^ sig_q[3] ^ ZN};
        if (last) begin
          state_d = FINISH;
          code_d  = '0;
          pass_d  = err_inc == '0;
        end else begin
          state_d = SETTLE;
          cnt_d   = CNT_INIT;
          idx_d   = nxt_idx;
          pas_d   = (idx_q == 3'd7) ? pas_q + 8'd1 : pas_q;
          code_d  = nxt_idx ^ (nxt_idx >> 1);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      pas_q   <= '0;
      code_q  <= '0;
      err_q   <= '0;
      ff_q    <= '0;
      sig_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pas_q   <= pas_d;
      code_q  <= code_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      sig_q   <= sig_d;
      pass_q  <= pass_d;
    end
  end
  assign {A3, A2, A1} = code_q;
  assign BUSY         = state_q == SETTLE || state_q == SAMPLE;
  assign DONE         = state_q == FINISH;
  assign PASS         = pass_q;
  assign ERR_CNT      = err_q;
  assign FIRST_FAIL   = ff_q;
  assign SIG          = sig_q;
endmodule

// File: tb/tb_gf180mcu_cell_bist3.sv
// tb_gf180mcu_cell_bist3: cycle-level model check of the default build plus parameter-variant runs
module tb_gf180mcu_cell_bist3;
  logic clk = 1'b0, rst = 1'b1, start0 = 1'b0, startx = 1'b0, zero = 1'b0;
  int mode = 0;
  int checks = 0, failures = 0;
  wire vdd = 1'b1, vss = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] a0, a1, a2, a3;
  logic       busy0, done0, pass0, busy1, done1, pass1, busy2, done2, pass2, busy3, done3, pass3;
  logic [7:0] err0, err1, err2, err3, sig0, sig1, sig2, sig3;
  logic [2:0] ff0, ff1, ff2, ff3;
  logic       zn0;
  logic [1:0] dl2 = 2'b11, dl3 = 2'b11;
  assign zn0 = mode == 0 ? ~&a0 : (mode == 1);
  always @(posedge clk) begin
    dl2 <= {dl2[0], ~&a2};
    dl3 <= {dl3[0], ~&a3};
  end

  gf180mcu_cell_bist3 dut0 (.CLK(clk), .RST(rst), .START(start0), .ZN(zn0), .A1(a0[0]), .A2(a0[1]), .A3(a0[2]),
    .BUSY(busy0), .DONE(done0), .PASS(pass0), .ERR_CNT(err0), .FIRST_FAIL(ff0), .SIG(sig0), .VDD(vdd), .VSS(vss));
  gf180mcu_cell_bist3 #(.PASSES(40)) dut1 (.CLK(clk), .RST(rst), .START(startx), .ZN(zero), .A1(a1[0]), .A2(a1[1]), .A3(a1[2]),
    .BUSY(busy1), .DONE(done1), .PASS(pass1), .ERR_CNT(err1), .FIRST_FAIL(ff1), .SIG(sig1), .VDD(vdd), .VSS(vss));
  gf180mcu_cell_bist3 #(.SETTLE_CYC(1)) dut2 (.CLK(clk), .RST(rst), .START(startx), .ZN(dl2[1]), .A1(a2[0]), .A2(a2[1]), .A3(a2[2]),
    .BUSY(busy2), .DONE(done2), .PASS(pass2), .ERR_CNT(err2), .FIRST_FAIL(ff2), .SIG(sig2), .VDD(vdd), .VSS(vss));
  gf180mcu_cell_bist3 #(.SETTLE_CYC(3)) dut3 (.CLK(clk), .RST(rst), .START(startx), .ZN(dl3[1]), .A1(a3[0]), .A2(a3[1]), .A3(a3[2]),
    .BUSY(busy3), .DONE(done3), .PASS(pass3), .ERR_CNT(err3), .FIRST_FAIL(ff3), .SIG(sig3), .VDD(vdd), .VSS(vss));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of dut0: t = cycles since the accepted START edge, -1 when idle
  localparam int S = 2, TEND = 8 * 1 * (S + 1);
  int         t = -1;
  bit         seen_rst = 0;
  logic [7:0] m_err = 0, m_sig = 0;
  logic [2:0] m_ff = 0;
  logic       m_pass = 0;

  function automatic logic [2:0] code_at(input int tt);
    int i;
    i = (tt / (S + 1)) % 8;
    return (tt >= 0 && tt < TEND) ? 3'(i ^ (i >> 1)) : 3'd0;
  endfunction

  always @(posedge clk) begin
    logic [2:0] c;
    logic       z;
    if (rst) begin
      t = -1; m_err = 0; m_sig = 0; m_ff = 0; m_pass = 0; seen_rst = 1;
    end else if (t < 0) begin
      if (start0) begin
        t = 0; m_err = 0; m_sig = 0; m_ff = 0; m_pass = 0;
      end
    end else begin
      if (t < TEND && t % (S + 1) == S) begin
        c = code_at(t);
        z = mode == 0 ? (c != 3'd7) : (mode == 1);
        if (z != (c != 3'd7)) begin
          if (m_err == 0) m_ff = c;
          if (m_err != 8'hFF) m_err = m_err + 8'd1;
        end
        m_sig = {m_sig[6:0], m_sig[7] ^ m_sig[5] ^ m_sig[4] ^ m_sig[3] ^ z};
      end
      t++;
      if (t == TEND) m_pass = (m_err == 0);
      else if (t > TEND) t = -1;
    end
  end

  always @(negedge clk) if (seen_rst) begin
    chk("A", 32'(a0), 32'(code_at(t)));
    chk("BUSY", 32'(busy0), 32'(t >= 0 && t < TEND));
    chk("DONE", 32'(done0), 32'(t == TEND));
    chk("PASS", 32'(pass0), 32'(m_pass));
    chk("ERR_CNT", 32'(err0), 32'(m_err));
    chk("FIRST_FAIL", 32'(ff0), 32'(m_ff));
    chk("SIG", 32'(sig0), 32'(m_sig));
  end

  task automatic wait_done0(output int n);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (done0) return;
    end
    chk("done0_timeout", 32'(done0), 32'd1);
  endtask

  task automatic run0(output int n);
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    n = 1;
    if (done0) return;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (done0) return;
    end
    chk("run0_timeout", 32'(done0), 32'd1);
  endtask

  initial begin
    int  n;
    bit  s2, s3;
    repeat (3) @(negedge clk);
    chk("rst_A", 32'(a0), 0);
    chk("rst_BUSY", 32'(busy0), 0);
    chk("rst_DONE", 32'(done0), 0);
    chk("rst_PASS", 32'(pass0), 0);
    chk("rst_ERR", 32'(err0), 0);
    chk("rst_FF", 32'(ff0), 0);
    chk("rst_SIG", 32'(sig0), 0);
    rst = 1'b0;
    // golden nand3
    mode = 0;
    run0(n);
    chk("gold_latency", 32'(n), 25);
    chk("gold_PASS", 32'(pass0), 1);
    chk("gold_ERR", 32'(err0), 0);
    chk("gold_FF", 32'(ff0), 0);
    chk("gold_SIG", 32'(sig0), 32'hF0);
    // stuck-at-1
    @(negedge clk);
    mode = 1;
    run0(n);
    chk("sa1_ERR", 32'(err0), 1);
    chk("sa1_FF", 32'(ff0), 7);
    chk("sa1_PASS", 32'(pass0), 0);
    chk("sa1_SIG", 32'(sig0), 32'hF4);
    // stuck-at-0, single pass
    @(negedge clk);
    mode = 2;
    run0(n);
    chk("sa0_ERR", 32'(err0), 7);
    chk("sa0_FF", 32'(ff0), 0);
    chk("sa0_SIG", 32'(sig0), 0);
    chk("sa0_PASS", 32'(pass0), 0);
    // reset mid-run
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_A", 32'(a0), 0);
    chk("mid_rst_BUSY", 32'(busy0), 0);
    chk("mid_rst_DONE", 32'(done0), 0);
    chk("mid_rst_ERR", 32'(err0), 0);
    chk("mid_rst_SIG", 32'(sig0), 0);
    rst = 1'b0;
    mode = 0;
    run0(n);
    chk("post_rst_PASS", 32'(pass0), 1);
    chk("post_rst_SIG", 32'(sig0), 32'hF0);
    // START held across run and FINISH
    @(negedge clk);
    start0 = 1'b1;
    wait_done0(n);
    @(negedge clk);
    chk("held_idle_BUSY", 32'(busy0), 0);
    chk("held_idle_DONE", 32'(done0), 0);
    @(negedge clk);
    chk("held_restart_BUSY", 32'(busy0), 1);
    start0 = 1'b0;
    wait_done0(n);
    chk("held_second_latency", 32'(n), 24);
    chk("held_PASS", 32'(pass0), 1);
    // parameter variants
    @(negedge clk);
    startx = 1'b1;
    @(negedge clk);
    startx = 1'b0;
    s2 = 0;
    s3 = 0;
    n = 0;
    while (!done1 && n < 1200) begin
      @(negedge clk);
      n++;
      s2 |= done2;
      s3 |= done3;
    end
    chk("p40_done", 32'(done1), 1);
    chk("p40_latency", 32'(n), 960);
    chk("p40_ERR", 32'(err1), 32'hFF);
    chk("p40_FF", 32'(ff1), 0);
    chk("p40_PASS", 32'(pass1), 0);
    chk("s1_done", 32'(s2), 1);
    chk("s1_err_nonzero", 32'(err2 != 0), 1);
    chk("s1_PASS", 32'(pass2), 0);
    chk("s3_done", 32'(s3), 1);
    chk("s3_ERR", 32'(err3), 0);
    chk("s3_PASS", 32'(pass3), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
